// File: rtl/tbu_mem_ctrl.sv
// Survivor-memory bank controller for Viterbi traceback: writes decisions round-robin into banks A-D.
// Optional frame counter output enabled by defining TBU_MEM_CTRL_FRAME_CNT_EN.
module tbu_mem_ctrl #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk,
  input  logic          RST,
  input  logic          enable,
  input  logic          in_valid,
  input  logic [63:0]   d_i,
  output logic [63:0]   d_o,
  output logic          wr_en_A,
  output logic          wr_en_B,
  output logic          wr_en_C,
  output logic          wr_en_D,
  output logic [AW-1:0] addr_A,
  output logic [AW-1:0] addr_B,
  output logic [AW-1:0] addr_C,
  output logic [AW-1:0] addr_D,
  output logic [1:0]    mem_bank,
  output logic          bank_done,
`ifdef TBU_MEM_CTRL_FRAME_CNT_EN
  output logic [15:0]   frame_cnt,
`endif
  output logic          tb_ready
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, FILL = 2'd1, RUN = 2'd2} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] wr_addr, wr_addr_nxt;
  logic [1:0]    bank, bank_nxt;

  logic [AW-1:0] rd_addr_c;
  logic          write_c;
  logic          last_c;

  logic [63:0]         d_o_q, d_o_nxt;
  logic [3:0]          wr_en_q, wr_en_nxt;
  logic [3:0][AW-1:0]  addr_q, addr_nxt;
  logic [1:0]          mem_bank_q, mem_bank_nxt;
  logic                bank_done_q, bank_done_nxt;
  logic                tb_ready_q, tb_ready_nxt;
  logic [15:0]         frame_q, frame_nxt;

  assign rd_addr_c = LAST_ADDR - wr_addr;
  assign write_c   = enable && (state != IDLE) && in_valid;
  assign last_c    = write_c && (wr_addr == LAST_ADDR);

  // State register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      wr_addr <= '0;
      bank    <= '0;
    end else begin
      state   <= state_nxt;
      wr_addr <= wr_addr_nxt;
      bank    <= bank_nxt;
    end
  end

  // Next-state and write-pointer logic; disable wins over everything
  always_comb begin
    state_nxt   = state;
    wr_addr_nxt = wr_addr;
    bank_nxt    = bank;
    if (!enable) begin
      state_nxt   = IDLE;
      wr_addr_nxt = '0;
      bank_nxt    = '0;
    end else if (state == IDLE) begin
      state_nxt = FILL;
    end else if (in_valid) begin
      if (last_c) begin
        wr_addr_nxt = '0;
        bank_nxt    = bank + 2'd1;
        if (state == FILL && bank == 2'd1) state_nxt = RUN;
      end else begin
        wr_addr_nxt = wr_addr + AW'(1);
      end
    end
  end

  // Output next-values; mem_bank and addresses only move on a write beat
  always_comb begin
    d_o_nxt       = d_o_q;
    wr_en_nxt     = '0;
    addr_nxt      = addr_q;
    mem_bank_nxt  = mem_bank_q;
    bank_done_nxt = 1'b0;
    tb_ready_nxt  = tb_ready_q;
    frame_nxt     = frame_q;
    if (!enable || state == IDLE) begin
      addr_nxt     = '0;
      mem_bank_nxt = '0;
      tb_ready_nxt = 1'b0;
      frame_nxt    = '0;
    end else if (in_valid) begin
      d_o_nxt         = d_i;
      wr_en_nxt[bank] = 1'b1;
      for (int i = 0; i < 4; i++) begin
        addr_nxt[i] = (bank == 2'(i)) ? wr_addr : rd_addr_c;
      end
      mem_bank_nxt  = bank;
      bank_done_nxt = last_c;
      if (state == RUN) tb_ready_nxt = 1'b1;
      if (last_c) frame_nxt = frame_q + 16'd1;
    end
  end

  // Output register
  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      d_o_q       <= '0;
      wr_en_q     <= '0;
      addr_q      <= '0;
      mem_bank_q  <= '0;
      bank_done_q <= 1'b0;
      tb_ready_q  <= 1'b0;
      frame_q     <= '0;
    end else begin
      d_o_q       <= d_o_nxt;
      wr_en_q     <= wr_en_nxt;
      addr_q      <= addr_nxt;
      mem_bank_q  <= mem_bank_nxt;
      bank_done_q <= bank_done_nxt;
      tb_ready_q  <= tb_ready_nxt;
      frame_q     <= frame_nxt;
    end
  end

  assign d_o       = d_o_q;
  assign wr_en_A   = wr_en_q[0];
  assign wr_en_B   = wr_en_q[1];
  assign wr_en_C   = wr_en_q[2];
  assign wr_en_D   = wr_en_q[3];
  assign addr_A    = addr_q[0];
  assign addr_B    = addr_q[1];
  assign addr_C    = addr_q[2];
  assign addr_D    = addr_q[3];
  assign mem_bank  = mem_bank_q;
  assign bank_done = bank_done_q;
  assign tb_ready  = tb_ready_q;
`ifdef TBU_MEM_CTRL_FRAME_CNT_EN
  assign frame_cnt = frame_q;
`else
  logic unused_frame_c;
  assign unused_frame_c = ^frame_q;
`endif

endmodule

// File: tb/tb_tbu_mem_ctrl.sv
// Directed bench for tbu_mem_ctrl with DEPTH=4: fill, RUN entry, wrap, gaps, enable drop, reset.
module tb_tbu_mem_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 2;

  logic          clk;
  logic          RST;
  logic          enable;
  logic          in_valid;
  logic [63:0]   d_i;
  logic [63:0]   d_o;
  logic          wr_en_A, wr_en_B, wr_en_C, wr_en_D;
  logic [AW-1:0] addr_A, addr_B, addr_C, addr_D;
  logic [1:0]    mem_bank;
  logic          bank_done;
  logic          tb_ready;
`ifdef TBU_MEM_CTRL_FRAME_CNT_EN
  logic [15:0]   frame_cnt;
`endif

  tbu_mem_ctrl #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .RST(RST), .enable(enable), .in_valid(in_valid), .d_i(d_i), .d_o(d_o),
    .wr_en_A(wr_en_A), .wr_en_B(wr_en_B), .wr_en_C(wr_en_C), .wr_en_D(wr_en_D),
    .addr_A(addr_A), .addr_B(addr_B), .addr_C(addr_C), .addr_D(addr_D),
    .mem_bank(mem_bank), .bank_done(bank_done),
`ifdef TBU_MEM_CTRL_FRAME_CNT_EN
    .frame_cnt(frame_cnt),
`endif
    .tb_ready(tb_ready)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int nwr    = 0;
  logic [63:0] last_d = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s writes=%0d observed=%0h expected=%0h", tag, nwr, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Everything at reset values except d_o, which may hold
  task automatic check_idle(input logic [63:0] exp_d);
    check("idle_d_o", d_o, exp_d);
    check("idle_wr_en", 64'({wr_en_D, wr_en_C, wr_en_B, wr_en_A}), 64'd0);
    check("idle_addr", 64'({addr_D, addr_C, addr_B, addr_A}), 64'd0);
    check("idle_mem_bank", 64'(mem_bank), 64'd0);
    check("idle_bank_done", 64'(bank_done), 64'd0);
    check("idle_tb_ready", 64'(tb_ready), 64'd0);
`ifdef TBU_MEM_CTRL_FRAME_CNT_EN
    check("idle_frame_cnt", 64'(frame_cnt), 64'd0);
`endif
  endtask

  // One cycle with or without a valid; expectations follow from the write count n
  task automatic beat(input logic valid, input logic [63:0] d);
    int n, b, wa;
    logic [7:0] exp_addr;
    logic [3:0] exp_wen;
    in_valid = valid;
    d_i      = d;
    step();
    if (valid) begin
      n = nwr;
      nwr++;
      last_d = d;
    end else begin
      n = nwr - 1;
    end
    b  = (n / 4) % 4;
    wa = n % 4;
    for (int x = 0; x < 4; x++) begin
      exp_addr[x*2 +: 2] = (x == b) ? 2'(wa) : 2'(3 - wa);
    end
    exp_wen = valid ? 4'(1 << b) : 4'd0;
    check("d_o", d_o, last_d);
    check("wr_en", 64'({wr_en_D, wr_en_C, wr_en_B, wr_en_A}), 64'(exp_wen));
    check("addr", 64'({addr_D, addr_C, addr_B, addr_A}), 64'(exp_addr));
    check("mem_bank", 64'(mem_bank), 64'(b));
    check("bank_done", 64'(bank_done), 64'(valid && wa == 3));
    check("tb_ready", 64'(tb_ready), 64'(n >= 8));
`ifdef TBU_MEM_CTRL_FRAME_CNT_EN
    check("frame_cnt", 64'(frame_cnt), 64'((n + 1) / 4));
`endif
  endtask

  initial begin
    clk = 1'b0; RST = 1'b1; enable = 1'b0; in_valid = 1'b0; d_i = '0;
    step();
    step();
    check_idle(64'd0);
    RST = 1'b0;

    // Valids while disabled are ignored
    in_valid = 1'b1; d_i = 64'h5;
    step(); check_idle(64'd0);
    step(); check_idle(64'd0);

    // Enable: one IDLE cycle, then fill A, B, RUN entry on C, wrap D->A
    enable = 1'b1; in_valid = 1'b0;
    step(); check_idle(64'd0);
    nwr = 0;
    for (int k = 0; k < 17; k++) beat(1'b1, 64'(k + 1));

    // Alternating valid / gap
    for (int k = 0; k < 6; k++) begin
      beat(1'b1, 64'hA000 + 64'(k));
      beat(1'b0, 64'h0);
    end

    // Back-to-back up to wr_addr=2 of bank D
    for (int k = 0; k < 7; k++) beat(1'b1, 64'hB000 + 64'(k));
    check("pre_drop_mem_bank", 64'(mem_bank), 64'd3);

    // Drop enable together with a valid: write dropped, d_o holds
    enable = 1'b0; in_valid = 1'b1; d_i = 64'hAA;
    step();
    check_idle(last_d);

    // Re-enable: first write to A at address 0
    enable = 1'b1; in_valid = 1'b0;
    step();
    nwr = 0;
    beat(1'b1, 64'hC001);
    beat(1'b1, 64'hC002);

    // Asynchronous reset mid-stream
    in_valid = 1'b1; d_i = 64'hDEAD;
    RST = 1'b1;
    step();
    check_idle(64'd0);
    RST = 1'b0;
    in_valid = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
